// File: rtl/p2s_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and its receivers/benches.
package p2s_tx_pkg;

  localparam int P2S_WIDTH = 16;
  localparam int P2S_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } p2s_state_t;

endpackage

// File: rtl/p2s_tx.sv
// Parallel-to-serial frame transmitter: MSB-first, variable length, one-cycle gap with done pulse.
module p2s_tx
  import p2s_tx_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH,
  parameter int LEN_W = P2S_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  output logic             data_out,
  output logic             enable,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  p2s_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  function automatic logic [CNT_W-1:0] frame_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? CNT_W'(WIDTH) : CNT_W'(l);
  endfunction

  // Left-justify the len-bit field so the serial bit is always the register MSB;
  // anything above bit L-1 falls off the top and is never sent.
  function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] d,
                                                 input logic [CNT_W-1:0] l);
    return d << (CNT_W'(WIDTH) - l);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = frame_len(len);
          shreg_nxt = align_msb(data_in, frame_len(len));
        end
      end
      ST_SHIFT: begin
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the shifted data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      enable <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
    end else begin
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      enable <= (state_nxt == ST_SHIFT);
      done   <= (state_nxt == ST_GAP);
      ready  <= (state_nxt == ST_IDLE);
      busy   <= (state_nxt != ST_IDLE);
    end
  end

  // After L shifts the justified register is all zeros, so the line idles low in GAP/IDLE.
  assign data_out = shreg[WIDTH-1];

endmodule

// File: tb/tb_p2s_tx.sv
// Scoreboard bench for p2s_tx: stimulus pushes expected bits/done tokens, a negedge monitor checks them.
module tb_p2s_tx;
  import p2s_tx_pkg::*;

  localparam int WIDTH = P2S_WIDTH;
  localparam int LEN_W = P2S_LEN_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [LEN_W-1:0] len = '0;
  logic             data_out, enable, ready, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  bit exp_bits[$];
  int exp_done[$];
  logic prev_en = 1'b0;

  // Simple receiver model sampling on the falling edge.
  logic [WIDTH-1:0] rx_word = '0;
  int               rx_cnt = 0;
  logic             rx_ready = 1'b0;

  p2s_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .len      (len),
    .data_out (data_out),
    .enable   (enable),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops one expected bit per enable cycle, one token per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_inv_ready", busy, !ready);
      if (enable) begin
        if (exp_bits.size() == 0) fail_now("unexpected_bit");
        else check("serial_bit", data_out, exp_bits.pop_front());
      end else begin
        check("idle_data_low", data_out, 1'b0);
      end
      if (done) begin
        check("done_after_last_bit", {prev_en, enable}, 2'b10);
        check("done_not_ready", ready, 1'b0);
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else void'(exp_done.pop_front());
      end
    end
    prev_en <= enable;
  end

  always @(negedge clk) begin
    if (enable) begin
      rx_word  <= (rx_cnt == 0) ? {{(WIDTH-1){1'b0}}, data_out} : {rx_word[WIDTH-2:0], data_out};
      rx_cnt   <= rx_cnt + 1;
      rx_ready <= (rx_cnt == 7);
    end else begin
      rx_cnt   <= 0;
      rx_ready <= 1'b0;
    end
  end

  // Queue the first nb bits of the frame (and a done token if it should complete), then pulse start.
  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                      input int nb, input bit push_done);
    int L = (l == '0) ? WIDTH : int'(l);
    int guard = 0;
    while (!ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", ready, 1'b1);
    for (int i = L - 1; i >= L - nb; i--) exp_bits.push_back(d[i]);
    if (push_done) exp_done.push_back(L);
    start   = 1'b1;
    data_in = d;
    len     = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_bit_latency", enable, 1'b1);
  endtask

  task automatic wait_frame();
    int guard = 0;
    while ((exp_bits.size() != 0 || exp_done.size() != 0 || !ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("frame_complete", (guard < 100), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Async reset before any clock edge
    #1 reset = 1'b1;
    #2;
    check("rst_data_out", data_out, 1'b0);
    check("rst_enable", enable, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // len=4, 0x000A -> 1,0,1,0 then done, then ready
    send(16'h000A, 4'd4, 4, 1'b1);
    begin
      int guard = 0;
      while (!done && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("done_seen", done, 1'b1);
    end
    @(negedge clk);
    check("ready_after_done", ready, 1'b1);
    check("done_single_cycle", done, 1'b0);
    wait_frame();

    // len=0 -> full 16-bit frame
    send(16'hA5C3, 4'd0, 16, 1'b1);
    wait_frame();

    // start/data changes while busy are ignored
    send(16'h005A, 4'd8, 8, 1'b1);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'hFFFF;
    len     = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_in_frame", busy, 1'b1);
      check("not_ready_in_frame", ready, 1'b0);
    end
    start = 1'b0;
    wait_frame();
    repeat (4) @(negedge clk);
    check("no_second_frame", enable, 1'b0);

    // len=1 -> single bit, done next cycle
    send(16'h0001, 4'd1, 1, 1'b1);
    wait_frame();

    // start held high: enable 1,1,0,0 repeating, data 1,0,0,0
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b0);
      exp_done.push_back(2);
    end
    start   = 1'b1;
    data_in = 16'h0002;
    len     = 4'd2;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) start = 1'b0;
      check("held_start_enable", enable, ((k % 4) < 2));
    end
    wait_frame();

    // Loopback into receiver model
    send(16'h005A, 4'd8, 8, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("rx_word", rx_word, 16'h005A);
    check("rx_ready_after_8th", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    check("rx_ready_drop_gap", rx_ready, 1'b0);
    wait_frame();

    // Reset mid-frame: len=8 0x00FF, abort during the 4th bit
    send(16'h00FF, 4'd8, 3, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_enable", enable, 1'b0);
    check("abort_data_out", data_out, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // First start accepted on the first edge after reset release
    send(16'h000A, 4'd4, 4, 1'b1);
    wait_frame();
    repeat (3) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("done_drained", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
